alarm_trigger: RTL and testbench

- Sits directly downstream of the alarm-set stage and consumes its alarm_hour/alarm_min outputs.
- Compares them against the running time-of-day from the clock counter.
- Drives the buzzer and status LEDs.
- Handles snooze, manual stop and automatic ring timeout through a small state machine clocked by the system clock and paced by a 1 Hz strobe.

---
 rtl/alarm_trigger.sv | 186 ++++++++++++++++++
 tb/tb_alarm_trigger.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares alarm time with time of day, drives buzzer/LEDs and runs ring/snooze/timeout FSM.
// Optional macro ALARM_BEEP_EN: buzzer beeps 1 s on / 1 s off while ringing instead of a steady tone.
module alarm_trigger #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_MIN     = 5,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       switch_set,
    input  logic       alarm_en,
    input  logic       key_snooze,
    input  logic       key_stop,
    output logic       buzzer,
    output logic       ring_LED,
    output logic       snooze_LED,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    localparam logic [7:0] RING_LIMIT  = 8'(RING_TIMEOUT_S);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
    localparam logic [2:0] SNOOZE_CAP  = 3'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic [9:0] snooze_tmr_q, snooze_tmr_d;
    logic [2:0] snooze_used_q, snooze_used_d;
    logic       key_snooze_q, key_stop_q;
    logic       buzzer_q, buzzer_d;
    logic       ring_led_q, ring_led_d;
    logic       snooze_led_q, snooze_led_d;

    logic       cancel;
    logic       stop_press;
    logic       snooze_press;
    logic       time_match;
    logic [7:0] ring_cnt_inc;

    // Keys are active-low; a press is the released-to-pressed edge against last cycle's sample.
    assign stop_press   = key_stop_q & ~key_stop;
    assign snooze_press = key_snooze_q & ~key_snooze;
    assign cancel       = ~alarm_en | switch_set;
    assign time_match   = tick_1hz && (cur_hour == alarm_hour) &&
                          (cur_min == alarm_min) && (cur_sec == 6'd0);
    assign ring_cnt_inc = ring_cnt_q + 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_cnt_q    <= 8'd0;
            snooze_tmr_q  <= 10'd0;
            snooze_used_q <= 3'd0;
            key_snooze_q  <= 1'b1;
            key_stop_q    <= 1'b1;
        end else begin
            ring_cnt_q    <= ring_cnt_d;
            snooze_tmr_q  <= snooze_tmr_d;
            snooze_used_q <= snooze_used_d;
            key_snooze_q  <= key_snooze;
            key_stop_q    <= key_stop;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d       = state_q;
        ring_cnt_d    = ring_cnt_q;
        snooze_tmr_d  = snooze_tmr_q;
        snooze_used_d = snooze_used_q;
        if (cancel) begin
            state_d       = ST_IDLE;
            ring_cnt_d    = 8'd0;
            snooze_tmr_d  = 10'd0;
            snooze_used_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (time_match) begin
                        state_d       = ST_RINGING;
                        ring_cnt_d    = 8'd0;
                        snooze_used_d = 3'd0;
                    end
                end
                ST_RINGING: begin
                    if (stop_press) begin
                        state_d       = ST_IDLE;
                        ring_cnt_d    = 8'd0;
                        snooze_used_d = 3'd0;
                    end else if (snooze_press && (snooze_used_q < SNOOZE_CAP)) begin
                        state_d       = ST_SNOOZE;
                        ring_cnt_d    = 8'd0;
                        snooze_tmr_d  = SNOOZE_LOAD;
                        snooze_used_d = snooze_used_q + 3'd1;
                    end else if (tick_1hz) begin
                        if (ring_cnt_inc == RING_LIMIT) begin
                            state_d       = ST_IDLE;
                            ring_cnt_d    = 8'd0;
                            snooze_used_d = 3'd0;
                        end else begin
                            ring_cnt_d = ring_cnt_inc;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_press) begin
                        state_d       = ST_IDLE;
                        snooze_tmr_d  = 10'd0;
                        snooze_used_d = 3'd0;
                    end else if (tick_1hz) begin
                        if (snooze_tmr_q <= 10'd1) begin
                            state_d      = ST_RINGING;
                            ring_cnt_d   = 8'd0;
                            snooze_tmr_d = 10'd0;
                        end else begin
                            snooze_tmr_d = snooze_tmr_q - 10'd1;
                        end
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    ring_cnt_d    = 8'd0;
                    snooze_tmr_d  = 10'd0;
                    snooze_used_d = 3'd0;
                end
            endcase
        end
    end

    // Output logic, evaluated on the next state so outputs line up with state
    always_comb begin
        ring_led_d   = (state_d == ST_RINGING);
        snooze_led_d = (state_d == ST_SNOOZE);
`ifdef ALARM_BEEP_EN
        buzzer_d = 1'b0;
        if (state_d == ST_RINGING) begin
            if (state_q != ST_RINGING) begin
                buzzer_d = 1'b1;
            end else if (tick_1hz) begin
                buzzer_d = ~buzzer_q;
            end else begin
                buzzer_d = buzzer_q;
            end
        end
`else
        buzzer_d = (state_d == ST_RINGING);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buzzer_q     <= 1'b0;
            ring_led_q   <= 1'b0;
            snooze_led_q <= 1'b0;
        end else begin
            buzzer_q     <= buzzer_d;
            ring_led_q   <= ring_led_d;
            snooze_led_q <= snooze_led_d;
        end
    end

    assign buzzer     = buzzer_q;
    assign ring_LED   = ring_led_q;
    assign snooze_LED = snooze_led_q;
    assign state      = state_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: driver queues expected output transitions, monitor checks them on change or probe.
module tb_alarm_trigger;

    localparam int RING_TIMEOUT_S = 60;
    localparam int SNOOZE_MIN     = 1;
    localparam int MAX_SNOOZE     = 2;
`ifdef ALARM_BEEP_EN
    localparam logic BEEP = 1'b1;
`else
    localparam logic BEEP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [5:0] cur_hour = 6'd0;
    logic [5:0] cur_min = 6'd0;
    logic [5:0] cur_sec = 6'd0;
    logic [5:0] alarm_hour = 6'd7;
    logic [5:0] alarm_min = 6'd30;
    logic       switch_set = 1'b0;
    logic       alarm_en = 1'b1;
    logic       key_snooze = 1'b1;
    logic       key_stop = 1'b1;
    logic       buzzer, ring_LED, snooze_LED;
    logic [1:0] state;

    alarm_trigger #(
        .RING_TIMEOUT_S(RING_TIMEOUT_S),
        .SNOOZE_MIN    (SNOOZE_MIN),
        .MAX_SNOOZE    (MAX_SNOOZE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1hz  (tick_1hz),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .switch_set(switch_set),
        .alarm_en  (alarm_en),
        .key_snooze(key_snooze),
        .key_stop  (key_stop),
        .buzzer    (buzzer),
        .ring_LED  (ring_LED),
        .snooze_LED(snooze_LED),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       ring;
        logic       snz;
        logic       buz;
        int         ticks;
        bit         chk_tick;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_num = 0;
    logic probe_req = 1'b0;
    logic mon_en = 1'b0;
    int   hh = 0, mm = 0, ss = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic [1:0] st, input logic buz,
                            input bit chk, input int ticks);
        exp_t e;
        e.name     = name;
        e.st       = st;
        e.ring     = (st == 2'd1);
        e.snz      = (st == 2'd2);
        e.buz      = buz;
        e.ticks    = ticks;
        e.chk_tick = chk;
        sb.push_back(e);
    endtask

    task automatic probe(input string name, input logic [1:0] st, input logic buz);
        push_exp(name, st, buz, 1'b0, 0);
        probe_req = 1'b1;
        step();
        probe_req = 1'b0;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        cur_hour = 6'(hh);
        cur_min  = 6'(mm);
        cur_sec  = 6'(ss);
        tick_num++;
        step();
        tick_1hz = 1'b0;
        ss++;
        if (ss == 60) begin ss = 0; mm++; end
        if (mm == 60) begin mm = 0; hh++; end
        if (hh == 24) hh = 0;
        repeat (3) step();
    endtask

    task automatic ticks(input int n);
        repeat (n) do_tick();
    endtask

    task automatic press(input bit stop, input bit snz, input int n_low);
        key_stop   = stop ? 1'b0 : 1'b1;
        key_snooze = snz ? 1'b0 : 1'b1;
        repeat (n_low) step();
        key_stop   = 1'b1;
        key_snooze = 1'b1;
        step();
    endtask

    // Fresh alarm event at 07:30:00; ring expected on the first tick of the scenario.
    task automatic start_ring(input string name);
        hh = 7; mm = 30; ss = 0;
        tick_num = 0;
        push_exp(name, 2'd1, 1'b1, 1'b1, 1);
        do_tick();
    endtask

    // Monitor: one scoreboard entry per output change or probe request
    initial begin
        logic [3:0] prev, cur;
        exp_t e;
        wait (mon_en);
        @(negedge clk);
        prev = {state, ring_LED, snooze_LED};
        forever begin
            @(negedge clk);
            cur = {state, ring_LED, snooze_LED};
            if (cur !== prev || probe_req) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got state=%0d ring=%0b snooze=%0b buzzer=%0b at tick %0d, expected no change",
                             state, ring_LED, snooze_LED, buzzer, tick_num);
                end else begin
                    e = sb.pop_front();
                    if (state !== e.st || ring_LED !== e.ring || snooze_LED !== e.snz ||
                        buzzer !== e.buz || (e.chk_tick && tick_num != e.ticks)) begin
                        errors++;
                        $display("FAIL %s: got state=%0d ring=%0b snooze=%0b buzzer=%0b tick=%0d, expected state=%0d ring=%0b snooze=%0b buzzer=%0b tick=%0d",
                                 e.name, state, ring_LED, snooze_LED, buzzer, tick_num,
                                 e.st, e.ring, e.snz, e.buz, e.chk_tick ? e.ticks : tick_num);
                    end else begin
                        $display("check %s: state=%0d ring=%0b snooze=%0b buzzer=%0b tick=%0d ok",
                                 e.name, state, ring_LED, snooze_LED, buzzer, tick_num);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) step();
        probe("reset_state", 2'd0, 1'b0);

        // Trigger: 07:29:58 -> 07:30:00, ring on the third tick
        hh = 7; mm = 29; ss = 58; tick_num = 0;
        push_exp("trigger", 2'd1, 1'b1, 1'b1, 3);
        ticks(3);
        repeat (2) step();

        // Stop held 10 cycles, then no re-fire at 07:30:01
        push_exp("stop", 2'd0, 1'b0, 1'b1, 3);
        press(1'b1, 1'b0, 10);
        ticks(3);
        probe("no_refire", 2'd0, 1'b0);

        // Timeout after 60 ticks, with buzzer pattern probes over the first ticks
        start_ring("timeout_ring");
        probe("beep_t0", 2'd1, 1'b1);
        do_tick();
        probe("beep_t1", 2'd1, BEEP ? 1'b0 : 1'b1);
        do_tick();
        probe("beep_t2", 2'd1, 1'b1);
        do_tick();
        probe("beep_t3", 2'd1, BEEP ? 1'b0 : 1'b1);
        push_exp("timeout_idle", 2'd0, 1'b0, 1'b1, 61);
        ticks(57);
        ticks(2);
        probe("timeout_buzzer_off", 2'd0, 1'b0);

        // Snooze limit: two snoozes honoured, third ignored
        start_ring("snz_ring0");
        push_exp("snz_enter1", 2'd2, 1'b0, 1'b1, 1);
        press(1'b0, 1'b1, 2);
        push_exp("snz_expire1", 2'd1, 1'b1, 1'b1, 61);
        ticks(60);
        push_exp("snz_enter2", 2'd2, 1'b0, 1'b1, 61);
        press(1'b0, 1'b1, 2);
        push_exp("snz_expire2", 2'd1, 1'b1, 1'b1, 121);
        ticks(60);
        press(1'b0, 1'b1, 2);
        probe("snz_third_ignored", 2'd1, 1'b1);
        push_exp("snz_stop", 2'd0, 1'b0, 1'b1, 121);
        press(1'b1, 1'b0, 2);

        // Cancel during snooze; no ring when the snooze would have expired
        start_ring("cancel_ring");
        push_exp("cancel_snooze", 2'd2, 1'b0, 1'b1, 1);
        press(1'b0, 1'b1, 2);
        ticks(10);
        push_exp("cancel_idle", 2'd0, 1'b0, 1'b1, 11);
        switch_set = 1'b1;
        repeat (2) step();
        switch_set = 1'b0;
        step();
        ticks(60);
        probe("cancel_no_ring", 2'd0, 1'b0);

        // Arming after second 0 of the alarm minute does not fire
        hh = 7; mm = 30; ss = 0;
        alarm_en = 1'b0;
        do_tick();
        alarm_en = 1'b1;
        ticks(2);
        probe("late_arm_no_fire", 2'd0, 1'b0);

        // Reset mid-ring
        start_ring("rst_ring");
        push_exp("rst_abort", 2'd0, 1'b0, 1'b1, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();

        // Stop and snooze in the same cycle: stop wins
        start_ring("both_ring");
        push_exp("both_stop_wins", 2'd0, 1'b0, 1'b1, 1);
        press(1'b1, 1'b1, 2);

        // Tick and stop in the same cycle: stop wins
        start_ring("tickstop_ring");
        push_exp("tickstop_idle", 2'd0, 1'b0, 1'b1, 2);
        key_stop = 1'b0;
        do_tick();
        key_stop = 1'b1;
        repeat (3) step();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no output event, expected state=%0d at tick %0d", e.name, e.st, e.ticks);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
